// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: schedules the two-digit display between keypad echo and timed messages
module seg_display_ctrl #(
    parameter int TICK_DIV    = 12000,
    parameter int MSG_TICKS   = 2000,
    parameter int BLINK_TICKS = 250,
    parameter int IDLE_TICKS  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_valid,
    input  logic [3:0] entry_digit,
    input  logic       entry_clear,
    input  logic       msg_req,
    input  logic [7:0] msg_data,
    input  logic       msg_blink,
    output logic [3:0] seg_data_1,
    output logic [3:0] seg_data_2,
    output logic       seg_blank_1,
    output logic       seg_blank_2,
    output logic       msg_busy
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int HW = MSG_TICKS > 1 ? $clog2(MSG_TICKS) : 1;
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
    localparam int IW = IDLE_TICKS > 1 ? $clog2(IDLE_TICKS) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] H_MAX = HW'(MSG_TICKS - 1);
    localparam logic [BW-1:0] B_MAX = BW'(BLINK_TICKS - 1);
    localparam logic [IW-1:0] I_MAX = IW'(IDLE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, ENTRY, MSG} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [3:0]    e1, e2, e1_nx, e2_nx;
    logic [1:0]    ecnt, ecnt_nx;
    logic [IW-1:0] idle_cnt;
    logic [HW-1:0] hold_cnt;
    logic [BW-1:0] bcnt;
    logic          phase, phase_nx;
    logic [7:0]    mdata, mdata_nx;
    logic          mblink, mblink_nx;
    logic          v, wipe, tmo, expire, btog;
    logic [3:0]    d1_nx, d2_nx;
    logic          b1_nx, b2_nx;

    assign tick = tcnt == T_MAX;

    // free-running tick prescaler
    always_ff @(posedge clk) begin
        if (rst) tcnt <= '0;
        else     tcnt <= tick ? '0 : tcnt + 1'b1;
    end

    // events and next values of the entry register and message latch
    always_comb begin
        v         = entry_valid & ~entry_clear;
        tmo       = state == ENTRY && tick && idle_cnt == I_MAX && !entry_valid && !msg_req;
        expire    = state == MSG && tick && hold_cnt == H_MAX;
        btog      = state == MSG && tick && bcnt == B_MAX && !msg_req;
        wipe      = entry_clear | tmo;
        e1_nx     = wipe ? 4'h0 : v ? e2 : e1;
        e2_nx     = wipe ? 4'h0 : v ? entry_digit : e2;
        ecnt_nx   = wipe ? 2'd0 : (v && ecnt != 2'd2) ? ecnt + 2'd1 : ecnt;
        mdata_nx  = msg_req ? msg_data : mdata;
        mblink_nx = msg_req ? msg_blink : mblink;
        phase_nx  = msg_req ? 1'b1 : btog ? ~phase : phase;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: a new message always wins, expiry returns to wherever the entry now points
    always_comb begin
        state_nx = state;
        if (msg_req)                         state_nx = MSG;
        else if (state == IDLE && v)         state_nx = ENTRY;
        else if (state == ENTRY && wipe)     state_nx = IDLE;
        else if (expire)                     state_nx = ecnt_nx != 2'd0 ? ENTRY : IDLE;
    end

    // display content for the upcoming state, registered below
    always_comb begin
        d1_nx = state_nx == MSG ? mdata_nx[7:4] : state_nx == ENTRY ? e1_nx : 4'h0;
        d2_nx = state_nx == MSG ? mdata_nx[3:0] : state_nx == ENTRY ? e2_nx : 4'h0;
        b1_nx = state_nx == MSG ? mblink_nx & ~phase_nx : state_nx == ENTRY ? ecnt_nx < 2'd2 : 1'b1;
        b2_nx = state_nx == MSG ? mblink_nx & ~phase_nx : state_nx == ENTRY ? ecnt_nx == 2'd0 : 1'b1;
    end

    // datapath registers: entry, message latch, hold/blink/idle counters, outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            e1          <= '0;
            e2          <= '0;
            ecnt        <= '0;
            mdata       <= '0;
            mblink      <= 1'b0;
            phase       <= 1'b0;
            idle_cnt    <= '0;
            hold_cnt    <= '0;
            bcnt        <= '0;
            seg_data_1  <= '0;
            seg_data_2  <= '0;
            seg_blank_1 <= 1'b1;
            seg_blank_2 <= 1'b1;
            msg_busy    <= 1'b0;
        end else begin
            e1          <= e1_nx;
            e2          <= e2_nx;
            ecnt        <= ecnt_nx;
            mdata       <= mdata_nx;
            mblink      <= mblink_nx;
            phase       <= phase_nx;
            idle_cnt    <= (state != ENTRY || entry_valid) ? '0 :
                           (tick && idle_cnt != I_MAX) ? idle_cnt + 1'b1 : idle_cnt;
            hold_cnt    <= msg_req ? '0 :
                           (state == MSG && tick && hold_cnt != H_MAX) ? hold_cnt + 1'b1 : hold_cnt;
            bcnt        <= msg_req ? '0 :
                           (state == MSG && tick) ? (bcnt == B_MAX ? '0 : bcnt + 1'b1) : bcnt;
            seg_data_1  <= d1_nx;
            seg_data_2  <= d2_nx;
            seg_blank_1 <= b1_nx;
            seg_blank_2 <= b2_nx;
            msg_busy    <= state_nx == MSG;
        end
    end
endmodule
